timer_counter: RTL

Programmable up-counter stage fed directly by the timer prescaler. It takes the prescaler's divided clock output as a tick input in the same `clk_in` domain and rising-edge-detects it. It counts prescaled ticks up to a programmable period, with one-shot or auto-reload mode, and produces compare-match and overflow pulses plus a sticky interrupt flag.

---
 rtl/timer_counter.sv | 100 ++++++++++
 1 files changed

// File: rtl/timer_counter.sv
// Programmable up-counter driven by rising edges of the prescaler tick.
// Supports one-shot or auto-reload operation, compare/overflow pulses and a sticky interrupt flag.
module timer_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             tick_in,
  input  logic             start,
  input  logic             stop,
  input  logic             auto_reload,
  input  logic [WIDTH-1:0] period,
  input  logic [WIDTH-1:0] compare,
  input  logic [1:0]       irq_en,
  input  logic             irq_clear,
  output logic [WIDTH-1:0] count_out,
  output logic             running,
  output logic             done,
  output logic             ovf_pulse,
  output logic             match_pulse,
  output logic             irq_flag
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             tick_d;
  logic             ovf_q, ovf_d;
  logic             match_q, match_d;
  logic             irq_q;
  logic             ev;
  logic             irq_set;

  assign ev = tick_in & ~tick_d & (state_q == RUN);

  // Command priority: stop over start, start over a same-cycle count event.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    ovf_d   = 1'b0;
    match_d = 1'b0;
    if (stop) begin
      state_d = IDLE;
    end else if (start) begin
      state_d = RUN;
      count_d = '0;
    end else if (ev) begin
      if (count_q == period) begin
        count_d = '0;
        ovf_d   = 1'b1;
        if (!auto_reload) state_d = DONE;
      end else begin
        count_d = count_q + 1'b1;
      end
      match_d = (count_d == compare);
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      count_q <= '0;
      tick_d  <= 1'b0;
      ovf_q   <= 1'b0;
      match_q <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      tick_d  <= tick_in;
      ovf_q   <= ovf_d;
      match_q <= match_d;
    end
  end

  // Flag is set from the registered pulses, so it trails them by one edge.
  assign irq_set = (ovf_q & irq_en[0]) | (match_q & irq_en[1]);

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      irq_q <= 1'b0;
    end else if (irq_set) begin
      irq_q <= 1'b1;
    end else if (irq_clear) begin
      irq_q <= 1'b0;
    end
  end

  assign count_out   = count_q;
  assign running     = (state_q == RUN);
  assign done        = (state_q == DONE);
  assign ovf_pulse   = ovf_q;
  assign match_pulse = match_q;
  assign irq_flag    = irq_q;

endmodule
